// File: rtl/dmni_mem_arbiter.sv
// Round-robin arbiter sharing the DMNI memory port among N_REQ DMA requesters, with bounded bursts.
// Optional build macro DMNI_MEM_ARB_PRIO_EN: requester 0 wins every IDLE arbitration in which it requests.
module dmni_mem_arbiter #(
    parameter int N_REQ     = 3,
    parameter int MAX_BURST = 16
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic [N_REQ-1:0]      req_i,
    input  logic [N_REQ*4-1:0]    we_i,
    input  logic [N_REQ*32-1:0]   addr_i,
    input  logic [N_REQ*32-1:0]   wdata_i,
    output logic [N_REQ-1:0]      gnt_o,
    output logic [N_REQ-1:0]      rvalid_o,
    output logic [31:0]           rdata_o,
    output logic                  mem_en_o,
    output logic [3:0]            mem_we_o,
    output logic [31:0]           mem_addr_o,
    output logic [31:0]           mem_data_o,
    input  logic [31:0]           mem_data_i
);

    localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int CNT_W = $clog2(MAX_BURST + 1);

    typedef enum logic {IDLE, BURST} state_t;

    state_t             state_q, state_d;
    logic [PTR_W-1:0]   owner_q, owner_d;
    logic [PTR_W-1:0]   rr_ptr_q, rr_ptr_d;
    logic [CNT_W-1:0]   beat_cnt_q, beat_cnt_d;
    logic               rd_pend_q, rd_pend_d;
    logic [PTR_W-1:0]   rd_id_q, rd_id_d;

    logic [PTR_W-1:0]   winner;
    logic               found;
    logic               acc;
    logic               last_beat;

    // Search starts just after the previous owner so every requester gets a turn.
    always_comb begin
        winner = rr_ptr_q;
        found  = 1'b0;
        for (int i = 1; i <= N_REQ; i++) begin
            if (!found && req_i[(int'(rr_ptr_q) + i) % N_REQ]) begin
                winner = PTR_W'((int'(rr_ptr_q) + i) % N_REQ);
                found  = 1'b1;
            end
        end
`ifdef DMNI_MEM_ARB_PRIO_EN
        if (req_i[0]) begin
            winner = '0;
        end
`else
`endif
    end

    assign acc       = (state_q == BURST) && req_i[owner_q];
    assign last_beat = acc && (beat_cnt_q == CNT_W'(MAX_BURST - 1));

    always_comb begin
        state_d    = state_q;
        owner_d    = owner_q;
        rr_ptr_d   = rr_ptr_q;
        beat_cnt_d = beat_cnt_q;
        rd_pend_d  = 1'b0;
        rd_id_d    = rd_id_q;
        gnt_o      = '0;
        mem_en_o   = 1'b0;
        mem_we_o   = '0;
        mem_addr_o = '0;
        mem_data_o = '0;
        rvalid_o   = '0;
        rdata_o    = '0;

        // Read data lands one cycle after acceptance, routed to the issuer only.
        if (rd_pend_q) begin
            rvalid_o[rd_id_q] = 1'b1;
            rdata_o           = mem_data_i;
        end

        case (state_q)
            IDLE: begin
                if (|req_i) begin
                    state_d    = BURST;
                    owner_d    = winner;
                    beat_cnt_d = '0;
                end
            end
            BURST: begin
                mem_en_o       = acc;
                mem_we_o       = we_i[int'(owner_q)*4 +: 4];
                mem_addr_o     = addr_i[int'(owner_q)*32 +: 32];
                mem_data_o     = wdata_i[int'(owner_q)*32 +: 32];
                gnt_o[owner_q] = acc;
                if (acc && (we_i[int'(owner_q)*4 +: 4] == 4'h0)) begin
                    rd_pend_d = 1'b1;
                    rd_id_d   = owner_q;
                end
                if (!acc || last_beat) begin
                    state_d  = IDLE;
                    rr_ptr_d = owner_q;
                end else begin
                    beat_cnt_d = beat_cnt_q + CNT_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= IDLE;
            owner_q    <= '0;
            rr_ptr_q   <= PTR_W'(N_REQ - 1);
            beat_cnt_q <= '0;
            rd_pend_q  <= 1'b0;
            rd_id_q    <= '0;
        end else begin
            state_q    <= state_d;
            owner_q    <= owner_d;
            rr_ptr_q   <= rr_ptr_d;
            beat_cnt_q <= beat_cnt_d;
            rd_pend_q  <= rd_pend_d;
            rd_id_q    <= rd_id_d;
        end
    end

endmodule

// File: tb/tb_dmni_mem_arbiter.sv
// Directed bench for dmni_mem_arbiter: 3 requesters, MAX_BURST=16, with a one-cycle-latency memory model.
module tb_dmni_mem_arbiter;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [2:0]    req = '0;
    logic [11:0]   we = '0;
    logic [95:0]   addr = '0;
    logic [95:0]   wdata = '0;
    logic [2:0]    gnt;
    logic [2:0]    rvalid;
    logic [31:0]   rdata;
    logic          mem_en;
    logic [3:0]    mem_we;
    logic [31:0]   mem_addr;
    logic [31:0]   mem_wdata;
    logic [31:0]   mem_rdata = '0;

    logic [31:0]   mem [0:255];
    logic          init_done = 1'b0;

    int n_total = 0;
    int n_pass  = 0;
    int n_fail  = 0;
    int cnt;
    int exp_owner;

    dmni_mem_arbiter #(.N_REQ(3), .MAX_BURST(16)) dut (
        .clk_i      (clk),
        .rst_ni     (rst_n),
        .req_i      (req),
        .we_i       (we),
        .addr_i     (addr),
        .wdata_i    (wdata),
        .gnt_o      (gnt),
        .rvalid_o   (rvalid),
        .rdata_o    (rdata),
        .mem_en_o   (mem_en),
        .mem_we_o   (mem_we),
        .mem_addr_o (mem_addr),
        .mem_data_o (mem_wdata),
        .mem_data_i (mem_rdata)
    );

    always #5 clk = ~clk;

    // Word memory preloaded with A000_0000 + word index on the first clock.
    always @(posedge clk) begin
        if (!init_done) begin
            for (int i = 0; i < 256; i++) mem[i] <= 32'hA000_0000 + 32'(i);
            init_done <= 1'b1;
        end else if (mem_en) begin
            if (mem_we == 4'h0) begin
                mem_rdata <= mem[mem_addr[9:2]];
            end else begin
                for (int b = 0; b < 4; b++)
                    if (mem_we[b]) mem[mem_addr[9:2]][8*b +: 8] <= mem_wdata[8*b +: 8];
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: got %h, expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_rq(input int r, input logic [3:0] w, input logic [31:0] a, input logic [31:0] d);
        we[r*4 +: 4]     = w;
        addr[r*32 +: 32] = a;
        wdata[r*32 +: 32] = d;
    endtask

    initial begin
        // Reset state
        tick();
        tick();
        chk("rst_gnt", gnt, 0);
        chk("rst_rvalid", rvalid, 0);
        chk("rst_mem_en", mem_en, 0);
        chk("rst_rdata", rdata, 0);
        rst_n = 1'b1;
        tick();

        // Test 1: single requester 1 reads 4 beats
        req = 3'b010;
        set_rq(1, 4'h0, 32'h100, 32'h0);
        #1;
        chk("t1_idle_gnt", gnt, 0);
        for (int k = 0; k < 4; k++) begin
            tick();
            set_rq(1, 4'h0, 32'h100 + 32'(4*k), 32'h0);
            #1;
            chk("t1_gnt", gnt, 3'b010);
            chk("t1_addr", mem_addr, 32'h100 + 32'(4*k));
            chk("t1_en", mem_en, 1);
            if (k > 0) begin
                chk("t1_rvalid", rvalid, 3'b010);
                chk("t1_rdata", rdata, 32'hA000_0040 + 32'(k-1));
            end
        end
        tick();
        req = 3'b000;
        #1;
        chk("t1_last_rvalid", rvalid, 3'b010);
        chk("t1_last_rdata", rdata, 32'hA000_0043);
        chk("t1_drop_gnt", gnt, 0);
        tick();
        chk("t1_no_rvalid", rvalid, 0);

        // Test 2: all three request continuously, from a fresh reset
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        req = 3'b111;
        for (int r = 0; r < 3; r++) set_rq(r, 4'hF, 32'h200 + 32'(4*r), 32'h1111_0000 + 32'(r));
        #1;
        chk("t2_idle0_en", mem_en, 0);
        for (int b = 0; b < 4; b++) begin
`ifdef DMNI_MEM_ARB_PRIO_EN
            exp_owner = 0;
`else
            exp_owner = b % 3;
`endif
            cnt = 0;
            repeat (16) begin
                tick();
                if (gnt == 3'(1 << exp_owner)) cnt++;
            end
            chk("t2_burst_len", cnt, 16);
            tick();
            chk("t2_bubble_en", mem_en, 0);
            chk("t2_bubble_gnt", gnt, 0);
        end

        // Test 3: owner 2 drops after 3 beats with requester 0 waiting
        req = 3'b100;
        tick();
        req = 3'b101;
        set_rq(0, 4'hF, 32'h40, 32'hDEAD_BEEF);
        #1;
        chk("t3_owner2", gnt, 3'b100);
        tick();
        chk("t3_beat2", gnt, 3'b100);
        tick();
        chk("t3_beat3", gnt, 3'b100);
        tick();
        req = 3'b001;
        #1;
        chk("t3_drop_gnt", gnt, 0);
        tick();
        chk("t3_idle_gnt", gnt, 0);
        chk("t3_idle_en", mem_en, 0);
        tick();
        chk("t3_owner0", gnt, 3'b001);

        // Test 4: requester 0 writes then reads back 0x40
        chk("t4_wr_we", mem_we, 4'hF);
        chk("t4_wr_addr", mem_addr, 32'h40);
        chk("t4_wr_data", mem_wdata, 32'hDEAD_BEEF);
        tick();
        set_rq(0, 4'h0, 32'h40, 32'h0);
        #1;
        chk("t4_rd_gnt", gnt, 3'b001);
        chk("t4_wr_norvalid", rvalid, 0);
        tick();
        req = 3'b000;
        #1;
        chk("t4_rvalid", rvalid, 3'b001);
        chk("t4_rdata", rdata, 32'hDEAD_BEEF);
        tick();
        chk("t4_after_rvalid", rvalid, 0);

        // Test 5: reset the cycle after a read is granted
        req = 3'b010;
        set_rq(1, 4'h0, 32'h104, 32'h0);
        tick();
        chk("t5_gnt1", gnt, 3'b010);
        tick();
        rst_n = 1'b0;
        req = 3'b011;
        #1;
        chk("t5_rst_rvalid", rvalid, 0);
        chk("t5_rst_rdata", rdata, 0);
        chk("t5_rst_gnt", gnt, 0);
        chk("t5_rst_en", mem_en, 0);
        tick();
        tick();
        rst_n = 1'b1;
        #1;
        chk("t5_rel_rvalid", rvalid, 0);
        chk("t5_rel_gnt", gnt, 0);
        tick();
        chk("t5_first0", gnt, 3'b001);
        chk("t5_first_rvalid", rvalid, 0);

        // Test 6: after 0's burst (rr_ptr=0), 0 and 1 both request
        tick();
        req = 3'b010;
        #1;
        chk("t6_drop_gnt", gnt, 0);
        chk("t6_rd_rvalid", rvalid, 3'b001);
        chk("t6_rd_rdata", rdata, 32'hDEAD_BEEF);
        tick();
        req = 3'b011;
        #1;
        chk("t6_idle_gnt", gnt, 0);
        tick();
`ifdef DMNI_MEM_ARB_PRIO_EN
        chk("t6_select", gnt, 3'b001);
`else
        chk("t6_select", gnt, 3'b010);
`endif
        req = 3'b000;
        tick();
        tick();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
